// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, branch/jump redirect and the
// IF/ID pipeline register, plus a saturating stall-cycle counter.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jmp,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      pc,
    output logic [31:0]      instr_id,
    output logic [31:0]      pc4_id,
    output logic             valid_id,
    output logic [5:0]       op_id,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] next_pc;
    logic        take_jmp;
    logic        redirect;
    logic        hold;

    assign pc_plus4    = pc + 32'd4;
    assign jump_target = {pc4_id[31:28], instr_id[25:0], 2'b00};
    assign take_jmp    = jmp & valid_id;
    assign redirect    = branch_taken | take_jmp;
    assign hold        = stall & ~redirect;

    assign imem_addr = pc;
    assign op_id     = valid_id ? instr_id[31:26] : 6'b0;

    // Branch from EX is older than a jump in ID, so it wins.
    always_comb begin
        next_pc = pc_plus4;
        if (branch_taken) begin
            next_pc = {branch_target[31:2], 2'b00};
        end else if (take_jmp) begin
            next_pc = jump_target;
        end else if (stall) begin
            next_pc = pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= {RESET_PC[31:2], 2'b00};
        end else begin
            pc <= next_pc;
        end
    end

    // A redirect squashes whatever was fetched this cycle.
    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            instr_id <= 32'h0;
            pc4_id   <= 32'h0;
            valid_id <= 1'b0;
        end else if (!stall) begin
            instr_id <= imem_rdata;
            pc4_id   <= pc_plus4;
            valid_id <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (hold && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural model, per-cycle compare,
// directed scenarios and randomized redirect/stall traffic.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jmp;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instr_id;
    logic [31:0] pc4_id;
    logic        valid_id;
    logic [5:0]  op_id;
    logic [15:0] stall_cnt;

    logic [31:0] s_imem_addr;
    logic [31:0] s_pc;
    logic [31:0] s_instr_id;
    logic [31:0] s_pc4_id;
    logic        s_valid_id;
    logic [5:0]  s_op_id;
    logic [3:0]  s_stall_cnt;

    logic        ovr_en = 1'b0;
    logic [31:0] ovr_addr = 32'h0;
    logic [31:0] ovr_data = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    int          m_cnt;

    always #5 clk = ~clk;

    assign imem_rdata = (ovr_en && imem_addr == ovr_addr) ?
                        ovr_data : (imem_addr ^ 32'hA5C3_5A3C);

    fetch_stage u_dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jmp(jmp), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .pc(pc), .instr_id(instr_id), .pc4_id(pc4_id),
        .valid_id(valid_id), .op_id(op_id), .stall_cnt(stall_cnt)
    );

    fetch_stage #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jmp(jmp), .imem_addr(s_imem_addr), .imem_rdata(imem_rdata),
        .pc(s_pc), .instr_id(s_instr_id), .pc4_id(s_pc4_id),
        .valid_id(s_valid_id), .op_id(s_op_id), .stall_cnt(s_stall_cnt)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ovr_en && a == ovr_addr) return ovr_data;
        return a ^ 32'hA5C3_5A3C;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(posedge clk) begin
        #2;
        check("pc", pc, m_pc);
        check("imem_addr", imem_addr, m_pc);
        check("instr_id", instr_id, m_instr);
        check("pc4_id", pc4_id, m_pc4);
        check("valid_id", {31'b0, valid_id}, {31'b0, m_valid});
        check("op_id", {26'b0, op_id},
              {26'b0, (m_valid ? m_instr[31:26] : 6'b0)});
        check("stall_cnt", {16'b0, stall_cnt},
              (m_cnt > 65535) ? 32'd65535 : m_cnt);
        check("sat_pc", s_pc, m_pc);
        check("sat_stall_cnt", {28'b0, s_stall_cnt},
              (m_cnt > 15) ? 32'd15 : m_cnt);
    end

    task automatic step(input logic r, input logic s, input logic b,
                        input logic [31:0] bt, input logic j);
        logic [31:0] n_pc, n_instr, n_pc4;
        logic        n_valid;
        int          n_cnt;
        rst = r; stall = s; branch_taken = b;
        branch_target = bt; jmp = j;
        n_pc = m_pc; n_instr = m_instr; n_pc4 = m_pc4;
        n_valid = m_valid; n_cnt = m_cnt;
        if (r) begin
            n_pc = 32'h0000_3000; n_instr = 0; n_pc4 = 0;
            n_valid = 0; n_cnt = 0;
        end else if (b) begin
            n_pc = bt & ~32'h3;
            n_instr = 0; n_pc4 = 0; n_valid = 0;
        end else if (j && m_valid) begin
            n_pc = {m_pc4[31:28], m_instr[25:0], 2'b00};
            n_instr = 0; n_pc4 = 0; n_valid = 0;
        end else if (s) begin
            n_cnt = m_cnt + 1;
        end else begin
            n_pc = m_pc + 32'd4;
            n_instr = mem_word(m_pc);
            n_pc4 = m_pc + 32'd4;
            n_valid = 1;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4;
        m_valid = n_valid; m_cnt = n_cnt;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0;
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 32'h1234, 1);
        check("lit_reset_pc", pc, 32'h0000_3000);
        check("lit_reset_valid", {31'b0, valid_id}, 32'h0);
        check("lit_reset_cnt", {16'b0, stall_cnt}, 32'h0);

        run(1);
        check("lit_run_pc1", pc, 32'h0000_3004);
        check("lit_run_pc4", pc4_id, 32'h0000_3004);
        check("lit_run_instr", instr_id, 32'h0000_3000 ^ 32'hA5C3_5A3C);
        check("lit_run_op", {26'b0, op_id}, 32'h29);
        run(2);
        check("lit_run_pc3", pc, 32'h0000_300C);

        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        check("lit_stall_pc", pc, 32'h0000_300C);
        check("lit_stall_pc4", pc4_id, 32'h0000_300C);
        check("lit_stall_cnt", {16'b0, stall_cnt}, 32'd3);
        run(1);
        check("lit_resume_pc", pc, 32'h0000_3010);

        step(0, 1, 1, 32'h0000_3043, 0);
        check("lit_brstall_pc", pc, 32'h0000_3040);
        check("lit_brstall_valid", {31'b0, valid_id}, 32'h0);
        check("lit_brstall_op", {26'b0, op_id}, 32'h0);
        check("lit_brstall_cnt", {16'b0, stall_cnt}, 32'd3);

        ovr_en = 1; ovr_addr = 32'h0000_3004; ovr_data = 32'h0C00_0C10;
        step(1, 0, 0, 0, 0);
        run(2);
        check("lit_jmp_instr", instr_id, 32'h0C00_0C10);
        check("lit_jmp_pc4", pc4_id, 32'h0000_3008);
        step(0, 0, 0, 0, 1);
        check("lit_jmp_pc", pc, 32'h0000_3040);
        check("lit_jmp_valid", {31'b0, valid_id}, 32'h0);
        step(0, 0, 0, 0, 1);
        check("lit_jmp_ignored", pc, 32'h0000_3044);
        ovr_en = 0;

        step(0, 0, 1, 32'hFFFF_FFFE, 0);
        check("lit_wrap_pre", pc, 32'hFFFF_FFFC);
        run(1);
        check("lit_wrap_pc", pc, 32'h0);
        check("lit_wrap_pc4", pc4_id, 32'h0);

        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0);
        check("lit_sat4", {28'b0, s_stall_cnt}, 32'hF);
        check("lit_cnt16", {16'b0, stall_cnt}, 32'd20);

        run(2);
        step(1, 0, 1, 32'h0000_5000, 0);
        check("lit_rstbr_pc", pc, 32'h0000_3000);
        check("lit_rstbr_valid", {31'b0, valid_id}, 32'h0);
        check("lit_rstbr_cnt", {16'b0, stall_cnt}, 32'h0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(49) == 0),
                 ($urandom_range(3) == 0),
                 ($urandom_range(7) == 0),
                 $urandom,
                 ($urandom_range(3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
